// File: rtl/wib_pkg.sv
// Shared WIB buffer geometry and fetch-sequencer state encoding.
package wib_pkg;
    localparam int WIB_AW    = 10;
    localparam int WIB_DW    = 19;
    localparam int WIB_DEPTH = 1 << WIB_AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/wib_fetch_fifo.sv
// First-word-fall-through FIFO between the WIB read return path and the PE stream.
module wib_fetch_fifo #(
    parameter  int DW         = 19,
    parameter  int FIFO_DEPTH = 4,
    localparam int PW         = $clog2(FIFO_DEPTH),
    localparam int CW         = PW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [DW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);
    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CW'(FIFO_DEPTH));
    assign o_count = count_q;
    assign do_pop  = i_pop & ~o_empty;
    // Head is forced to zero when empty so the stream data is clean during and after reset.
    assign o_rdata = o_empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = i_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({i_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) mem_q[wr_ptr_q] <= i_wdata;
    end
endmodule

// File: rtl/wib_fetch_ctrl.sv
// WIB read sequencer: issues credit-limited reads, realigns the fixed-latency
// return data and streams it to the PE array through a FWFT FIFO.
module wib_fetch_ctrl
    import wib_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = WIB_AW,
    parameter int DW         = WIB_DW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [AW-1:0] i_base_addr,
    input  logic [AW:0]   i_len,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW-1:0] o_wib_raddr,
    output logic          o_wib_rd_en,
    input  logic [DW-1:0] i_wib_rdat,
    output logic [DW-1:0] o_w_data,
    output logic          o_w_vld,
    input  logic          i_w_rdy
);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] DEPTH_C = CW1'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_L   = (AW + 1)'(1);

    fetch_state_e      state_q, state_d;
    logic [AW-1:0]     addr_cnt_q, addr_cnt_d;
    logic [AW:0]       issue_cnt_q, issue_cnt_d;
    logic [AW:0]       out_cnt_q, out_cnt_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
    logic              rd_en_q, rd_en_d;
    logic [AW-1:0]     raddr_q, raddr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              issue, ret, pop;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_cnt;
    logic [CW:0]       credit_used;

    // The RAM's own data-valid is ignored; the tap of this pipe marks returning words.
    assign ret         = vld_pipe_q[RD_LAT-1];
    assign pop         = o_w_vld & i_w_rdy;
    assign credit_used = {1'b0, fifo_cnt} + {1'b0, inflight_q};
    // A word holds a credit from issue until it is popped, so the FIFO can never overflow.
    assign issue       = (state_q == FETCH) && (issue_cnt_q != '0) && (credit_used < DEPTH_C);

    always_comb begin
        vld_pipe_d = (vld_pipe_q << 1) | RD_LAT'(rd_en_q);
        inflight_d = inflight_q;
        case ({issue, ret})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_cnt_d  = addr_cnt_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_en_d     = issue;
        raddr_d     = raddr_q;
        if (issue) begin
            raddr_d     = addr_cnt_q;
            addr_cnt_d  = addr_cnt_q + AW'(1);
            issue_cnt_d = issue_cnt_q - ONE_L;
        end
        if (pop && out_cnt_q != '0) out_cnt_d = out_cnt_q - ONE_L;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (i_len != '0) begin
                        state_d     = FETCH;
                        addr_cnt_d  = i_base_addr;
                        issue_cnt_d = i_len;
                        out_cnt_d   = i_len;
                        busy_d      = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (issue && issue_cnt_q == ONE_L) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && out_cnt_q == ONE_L) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            addr_cnt_q  <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= '0;
            vld_pipe_q  <= '0;
            rd_en_q     <= 1'b0;
            raddr_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_cnt_q  <= addr_cnt_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            inflight_q  <= inflight_d;
            vld_pipe_q  <= vld_pipe_d;
            rd_en_q     <= rd_en_d;
            raddr_q     <= raddr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    wib_fetch_fifo #(
        .DW         (DW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (ret),
        .i_wdata (i_wib_rdat),
        .i_pop   (pop),
        .o_rdata (o_w_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_cnt)
    );

    assign o_w_vld     = ~fifo_empty;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_wib_rd_en = rd_en_q;
    assign o_wib_raddr = raddr_q;

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(ret && fifo_full && !pop));
endmodule

// File: tb/tb_wib_fetch_ctrl.sv
// Two DUTs (RD_LAT=2 and RD_LAT=1) driven in lockstep against per-DUT RAM models
// and an address/word scoreboard built from the command alone.
module tb_wib_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, start, rdy;
    logic [9:0]  base;
    logic [10:0] len;

    logic [1:0]        busy, done, rd_en, w_vld;
    logic [1:0][9:0]   raddr;
    logic [1:0][18:0]  w_data, rdat;

    int total = 0;
    int bad   = 0;
    int exp_done = 0;
    int rd_cnt[2], out_cnt[2], done_cnt[2];
    bit rand_rdy = 1'b0;
    bit prev_stall[2];
    logic [18:0] prev_data[2];
    logic [9:0]  exp_addr[2][$];
    logic [18:0] exp_data[2][$];

    always #5 clk = ~clk;

    wib_fetch_ctrl #(.RD_LAT(2)) u_dut_lat2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base), .i_len(len),
        .o_busy(busy[0]), .o_done(done[0]), .o_wib_raddr(raddr[0]), .o_wib_rd_en(rd_en[0]),
        .i_wib_rdat(rdat[0]), .o_w_data(w_data[0]), .o_w_vld(w_vld[0]), .i_w_rdy(rdy)
    );

    wib_fetch_ctrl #(.RD_LAT(1)) u_dut_lat1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base), .i_len(len),
        .o_busy(busy[1]), .o_done(done[1]), .o_wib_raddr(raddr[1]), .o_wib_rd_en(rd_en[1]),
        .i_wib_rdat(rdat[1]), .o_w_data(w_data[1]), .o_w_vld(w_vld[1]), .i_w_rdy(rdy)
    );

    function automatic logic [18:0] ram_word(input logic [9:0] a);
        return {a[4:0], ~a, a[9:6]};
    endfunction

    // RAM models: data appears RD_LAT cycles after rd_en, random junk otherwise.
    logic [1:0][10:0] st0, st1;
    logic [18:0] junk;
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            st0[d] <= {rd_en[d], raddr[d]};
            st1[d] <= st0[d];
        end
        junk <= 19'($urandom);
    end
    assign rdat[0] = st1[0][10] ? ram_word(st1[0][9:0]) : junk;
    assign rdat[1] = st0[1][10] ? ram_word(st0[1][9:0]) : junk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) prev_stall[d] = 1'b0;
            if (rd_en[d]) begin
                rd_cnt[d]++;
                chk($sformatf("rd_expected%0d", d), 64'(exp_addr[d].size() > 0), 1);
                if (exp_addr[d].size() > 0) chk($sformatf("raddr%0d", d), raddr[d], exp_addr[d].pop_front());
            end
            if (prev_stall[d]) begin
                chk($sformatf("stall_vld%0d", d), w_vld[d], 1);
                chk($sformatf("stall_data%0d", d), w_data[d], prev_data[d]);
            end
            if (w_vld[d] && rdy) begin
                out_cnt[d]++;
                chk($sformatf("word_expected%0d", d), 64'(exp_data[d].size() > 0), 1);
                if (exp_data[d].size() > 0) chk($sformatf("wdata%0d", d), w_data[d], exp_data[d].pop_front());
            end
            if (done[d]) begin
                done_cnt[d]++;
                chk($sformatf("busy_at_done%0d", d), busy[d], 0);
            end
            prev_stall[d] = rst_n && w_vld[d] && !rdy;
            prev_data[d]  = w_data[d];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic issue_start(input logic [9:0] b, input logic [10:0] l, input bit accept);
        start = 1'b1;
        base  = b;
        len   = l;
        if (accept) begin
            for (int i = 0; i < int'(l); i++) begin
                for (int d = 0; d < 2; d++) begin
                    exp_addr[d].push_back(10'(int'(b) + i));
                    exp_data[d].push_back(ram_word(10'(int'(b) + i)));
                end
            end
            exp_done++;
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((done_cnt[0] < exp_done || done_cnt[1] < exp_done) && n < budget) begin
            step();
            n++;
        end
        repeat (4) step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("done_count%0d", d), done_cnt[d], exp_done);
            chk($sformatf("words_left%0d", d), exp_data[d].size(), 0);
            chk($sformatf("reads_left%0d", d), exp_addr[d].size(), 0);
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        for (int d = 0; d < 2; d++)
            chk($sformatf("%s%0d", tag, d),
                {busy[d], done[d], rd_en[d], raddr[d], w_vld[d], w_data[d]}, 0);
    endtask

    initial begin
        int r0, r1, o0, o1, dc, n;
        rst_n = 1'b0; start = 1'b0; base = '0; len = '0; rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outs_zero("reset_outs");
        rst_n = 1'b1;
        step();

        // Basic fetch with exact first-word latency.
        rdy = 1'b1;
        r0 = rd_cnt[0]; r1 = rd_cnt[1];
        issue_start(10'h010, 11'd8, 1'b1);
        chk("t1_busy0", busy[0], 1);
        chk("t1_busy1", busy[1], 1);
        step();
        chk("t1_rd_en0", rd_en[0], 1);
        chk("t1_raddr0", raddr[0], 10'h010);
        step();
        chk("t1_vld0_e2", w_vld[0], 0);
        chk("t1_vld1_e2", w_vld[1], 0);
        step();
        chk("t1_vld0_e3", w_vld[0], 0);
        chk("t1_vld1_e3", w_vld[1], 1);
        step();
        chk("t1_vld0_e4", w_vld[0], 1);
        wait_done(100);
        chk("t1_reads0", rd_cnt[0] - r0, 8);
        chk("t1_reads1", rd_cnt[1] - r1, 8);

        // Address wrap.
        issue_start(10'h3FE, 11'd4, 1'b1);
        wait_done(100);

        // Stall with ready low: credits cap outstanding reads.
        rdy = 1'b0;
        r0 = rd_cnt[0]; r1 = rd_cnt[1];
        issue_start(10'h040, 11'd16, 1'b1);
        repeat (19) step();
        chk("t3_reads0", rd_cnt[0] - r0, 4);
        chk("t3_reads1", rd_cnt[1] - r1, 4);
        chk("t3_vld0", w_vld[0], 1);
        chk("t3_vld1", w_vld[1], 1);
        rdy = 1'b1;
        wait_done(200);

        // Zero length and start-while-busy.
        rdy = 1'b1;
        r0 = rd_cnt[0]; r1 = rd_cnt[1];
        issue_start(10'h055, 11'd0, 1'b1);
        chk("t5_done0", done[0], 1);
        chk("t5_done1", done[1], 1);
        chk("t5_busy0", busy[0], 0);
        step();
        chk("t5_done0_off", done[0], 0);
        chk("t5_len0_reads", rd_cnt[0] - r0, 0);
        issue_start(10'h100, 11'd8, 1'b1);
        repeat (3) step();
        issue_start(10'h200, 11'd5, 1'b0);
        wait_done(100);
        chk("t5_reads0", rd_cnt[0] - r0, 8);
        chk("t5_reads1", rd_cnt[1] - r1, 8);

        // Full-length wrap with random ready, then a random command.
        rand_rdy = 1'b1;
        issue_start(10'h3FF, 11'd1024, 1'b1);
        wait_done(8000);
        issue_start(10'($urandom), 11'($urandom_range(1, 300)), 1'b1);
        wait_done(2000);
        rand_rdy = 1'b0;
        rdy = 1'b1;

        // Reset in the middle of a fetch.
        o0 = out_cnt[0];
        issue_start(10'h020, 11'd10, 1'b1);
        n = 0;
        while (out_cnt[0] - o0 < 3 && n < 50) begin
            step();
            n++;
        end
        chk("t6_words_before_rst", 64'(out_cnt[0] - o0 >= 3), 1);
        rst_n = 1'b0;
        #1;
        chk_outs_zero("midrst_outs");
        exp_done--;
        dc = done_cnt[0];
        for (int d = 0; d < 2; d++) begin
            exp_addr[d].delete();
            exp_data[d].delete();
        end
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("t6_no_done", done_cnt[0] - dc, 0);
        o0 = out_cnt[0]; o1 = out_cnt[1];
        issue_start(10'h030, 11'd2, 1'b1);
        wait_done(100);
        chk("t6_words0", out_cnt[0] - o0, 2);
        chk("t6_words1", out_cnt[1] - o1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
